bad_point_list_writer: RTL and testbench

BAD_POINT_LIST_WRITER -- requirements
Module: bad_point_list_writer

---
 rtl/bad_point_list_writer.sv | 148 ++++++++++++++
 tb/tb_bad_point_list_writer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bad_point_list_writer.sv
// bad_point_list_writer: records the coordinates of bad pixels from one full frame into a LUT.
// Optional: define BPW_MERGE_ADJ_EN to skip bad pixels already covered by the previous entry.
`default_nettype none
`timescale 1ns/1ps

module bad_point_list_writer #(
  parameter int WIDTH_BITS    = 10,
  parameter int HEIGHT_BITS   = 10,
  parameter int BAD_POINT_NUM = 128,
  parameter int BAD_POINT_BIT = 7,
  parameter int IMAGE_WIDTH   = 640,
  parameter int IMAGE_HEIGHT  = 512
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     capture_start,
  input  logic                     frame_start,
  input  logic                     pixel_valid,
  input  logic [WIDTH_BITS-1:0]    current_x,
  input  logic [HEIGHT_BITS-1:0]   current_y,
  input  logic                     bad_flag,
  output logic                     wen_lut,
  output logic [BAD_POINT_BIT-1:0] waddr_lut,
  output logic [31:0]              wdata_lut,
  output logic [BAD_POINT_BIT-1:0] bad_point_num,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_COLLECT = 2'd2;
  localparam logic [1:0] S_COMMIT  = 2'd3;

  localparam logic [BAD_POINT_BIT-1:0] CAPACITY = BAD_POINT_BIT'(BAD_POINT_NUM - 1);

  logic [1:0]               state;
  logic [1:0]               state_nxt;
  logic                     fs_q;
  logic [BAD_POINT_BIT-1:0] count;
  logic                     sof_edge;
  logic                     qualify;
  logic                     suppress;
  logic                     entry;
  logic                     collect_px;
  logic                     full;
  logic                     do_write;
  logic                     do_drop;

  assign sof_edge   = frame_start & ~fs_q;
  assign qualify    = pixel_valid && bad_flag &&
                      (32'(current_x) < IMAGE_WIDTH) && (32'(current_y) < IMAGE_HEIGHT);
  assign entry      = (state == S_ARMED) && sof_edge;
  assign full       = (count == CAPACITY);
  // The edge cycle that ends COLLECT carries pixel (0,0) of the following frame.
  assign collect_px = (state == S_COLLECT) && !sof_edge && qualify && !suppress;
  // Pixel (0,0) on the entry edge is always written: count and merge history start empty.
  assign do_write   = (entry && qualify) || (collect_px && !full);
  assign do_drop    = collect_px && full;

`ifdef BPW_MERGE_ADJ_EN
  logic                   hist_vld;
  logic [WIDTH_BITS-1:0]  last_x;
  logic [HEIGHT_BITS-1:0] last_y;

  // Unsigned difference: a pixel left of the last entry wraps large and is never merged.
  assign suppress = hist_vld && (current_y == last_y) &&
                    ((current_x - last_x) <= WIDTH_BITS'(2));

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_vld <= 1'b0;
      last_x   <= '0;
      last_y   <= '0;
    end else if (do_write) begin
      hist_vld <= 1'b1;
      last_x   <= current_x;
      last_y   <= current_y;
    end else if (entry) begin
      hist_vld <= 1'b0;
    end
  end
`else
  assign suppress = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (capture_start) state_nxt = S_ARMED;
      S_ARMED:   if (sof_edge)      state_nxt = S_COLLECT;
      S_COLLECT: if (sof_edge)      state_nxt = S_COMMIT;
      S_COMMIT:                     state_nxt = S_IDLE;
      default:                      state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fs_q          <= 1'b0;
      wen_lut       <= 1'b0;
      waddr_lut     <= '0;
      wdata_lut     <= '0;
      bad_point_num <= '0;
      count         <= '0;
      done          <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      fs_q    <= frame_start;
      wen_lut <= do_write;
      done    <= (state == S_COMMIT);
      if (do_write) begin
        waddr_lut <= entry ? '0 : count;
        wdata_lut <= {16'(current_y), 16'(current_x)};
      end
      if (entry) begin
        // Zeroing bad_point_num keeps downstream lookups off while the LUT is rewritten.
        count         <= qualify ? BAD_POINT_BIT'(1) : '0;
        overflow      <= 1'b0;
        bad_point_num <= '0;
      end else if (do_write) begin
        count <= count + BAD_POINT_BIT'(1);
      end
      if (do_drop) begin
        overflow <= 1'b1;
      end
      if (state == S_COMMIT) begin
        bad_point_num <= count;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bad_point_list_writer.sv
// Testbench for bad_point_list_writer: per-scenario tasks checked against a list-based frame model.
`default_nettype none
`timescale 1ns/1ps

module tb_bad_point_list_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        capture_start;
  logic        frame_start;
  logic        pixel_valid;
  logic [9:0]  current_x;
  logic [9:0]  current_y;
  logic        bad_flag;
  logic        wen_lut;
  logic [6:0]  waddr_lut;
  logic [31:0] wdata_lut;
  logic [6:0]  bad_point_num;
  logic        busy;
  logic        done;
  logic        overflow;

  bad_point_list_writer dut (
    .clk(clk), .rst(rst), .capture_start(capture_start), .frame_start(frame_start),
    .pixel_valid(pixel_valid), .current_x(current_x), .current_y(current_y),
    .bad_flag(bad_flag), .wen_lut(wen_lut), .waddr_lut(waddr_lut), .wdata_lut(wdata_lut),
    .bad_point_num(bad_point_num), .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int prev_bpn = 0;
  int px_x[$];
  int px_y[$];
  bit px_v[$];
  bit px_b[$];
  logic [38:0] obs_w[$];
  int          done_cnt;
  logic [6:0]  bpn_at_done;

  always @(negedge clk) begin
    if (wen_lut) obs_w.push_back({waddr_lut, wdata_lut});
    if (done) begin
      done_cnt++;
      bpn_at_done = bad_point_num;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int x, input int y, input bit v, input bit b);
    current_x   = 10'(x);
    current_y   = 10'(y);
    pixel_valid = v;
    bad_flag    = b;
  endtask

  task automatic clear_px();
    px_x.delete(); px_y.delete(); px_v.delete(); px_b.delete();
  endtask

  task automatic add_px(input int x, input int y, input bit v, input bit b);
    px_x.push_back(x); px_y.push_back(y); px_v.push_back(v); px_b.push_back(b);
  endtask

  // Element 0 is presented on the opening SOF edge; a terminating SOF edge follows the list.
  task automatic run_frame(input string name, input bit last_bad, input int cap_idx);
    logic [38:0] exp_w[$];
    int  cnt;
    bit  ovf;
    bit  have;
    int  lx;
    int  ly;
    int  n;
    cnt = 0; ovf = 0; have = 0; lx = 0; ly = 0;
    foreach (px_x[i]) begin
      if (!(px_v[i] && px_b[i] && px_x[i] < 640 && px_y[i] < 512)) continue;
`ifdef BPW_MERGE_ADJ_EN
      if (have && px_y[i] == ly && px_x[i] >= lx && px_x[i] - lx <= 2) continue;
`endif
      if (cnt == 127) begin
        ovf = 1;
        continue;
      end
      exp_w.push_back({7'(cnt), 16'(px_y[i]), 16'(px_x[i])});
      cnt++;
      have = 1; lx = px_x[i]; ly = px_y[i];
    end

    obs_w.delete();
    done_cnt = 0;
    capture_start = 1'b1;
    tick();
    capture_start = 1'b0;
    tick();
    tick();
    tests++;
    if (busy !== 1'b1 || bad_point_num !== 7'(prev_bpn)) begin
      fails++;
      $display("FAIL %s_armed: busy=%b bpn=%0d, want busy=1 bpn=%0d", name, busy, bad_point_num, prev_bpn);
    end
    foreach (px_x[i]) begin
      frame_start   = (i == 0);
      capture_start = (i == cap_idx);
      drive(px_x[i], px_y[i], px_v[i], px_b[i]);
      tick();
    end
    capture_start = 1'b0;
    frame_start   = 1'b1;
    drive(0, 0, 1'b1, last_bad);
    tick();
    frame_start = 1'b0;
    drive(0, 0, 1'b0, 1'b0);
    for (int k = 0; k < 20 && done_cnt == 0; k++) tick();
    tick();
    tick();

    tests++;
    if (done_cnt !== 1) begin
      fails++;
      $display("FAIL %s_done: done cycles=%0d, want 1", name, done_cnt);
    end
    tests++;
    if (obs_w.size() !== exp_w.size()) begin
      fails++;
      $display("FAIL %s_nwrites: got %0d writes, want %0d", name, obs_w.size(), exp_w.size());
    end
    n = (obs_w.size() < exp_w.size()) ? obs_w.size() : exp_w.size();
    for (int i = 0; i < n; i++) begin
      tests++;
      if (obs_w[i] !== exp_w[i]) begin
        fails++;
        $display("FAIL %s_write%0d: addr=%0d data=%h, want addr=%0d data=%h", name, i,
                 obs_w[i][38:32], obs_w[i][31:0], exp_w[i][38:32], exp_w[i][31:0]);
      end
    end
    tests++;
    if (bpn_at_done !== 7'(cnt) || bad_point_num !== 7'(cnt)) begin
      fails++;
      $display("FAIL %s_bpn: at_done=%0d now=%0d, want %0d", name, bpn_at_done, bad_point_num, cnt);
    end
    tests++;
    if (overflow !== ovf || busy !== 1'b0 || wen_lut !== 1'b0) begin
      fails++;
      $display("FAIL %s_status: ovf=%b busy=%b wen=%b, want ovf=%b busy=0 wen=0", name, overflow, busy, wen_lut, ovf);
    end
    prev_bpn = cnt;
  endtask

  task automatic test_reset();
    rst = 1'b1; capture_start = 1'b0; frame_start = 1'b0;
    drive(0, 0, 1'b0, 1'b0);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    tests++; if (wen_lut !== 1'b0)        begin fails++; $display("FAIL rst_wen: %b, want 0", wen_lut); end
    tests++; if (waddr_lut !== 7'd0)      begin fails++; $display("FAIL rst_waddr: %0d, want 0", waddr_lut); end
    tests++; if (wdata_lut !== 32'd0)     begin fails++; $display("FAIL rst_wdata: %h, want 0", wdata_lut); end
    tests++; if (bad_point_num !== 7'd0)  begin fails++; $display("FAIL rst_bpn: %0d, want 0", bad_point_num); end
    tests++; if (busy !== 1'b0)           begin fails++; $display("FAIL rst_busy: %b, want 0", busy); end
    tests++; if (done !== 1'b0)           begin fails++; $display("FAIL rst_done: %b, want 0", done); end
    tests++; if (overflow !== 1'b0)       begin fails++; $display("FAIL rst_ovf: %b, want 0", overflow); end
    prev_bpn = 0;
  endtask

  task automatic test_basic();
    clear_px();
    add_px(0, 0, 1, 0);   add_px(5, 3, 1, 1);    add_px(6, 3, 1, 0);
    add_px(100, 3, 1, 1); add_px(50, 50, 0, 1);  add_px(7, 200, 1, 1);
    add_px(8, 200, 1, 0);
    run_frame("basic", 1'b0, -1);
  endtask

  task automatic test_merge();
    clear_px();
    add_px(0, 0, 1, 0);
    add_px(10, 4, 1, 1); add_px(11, 4, 1, 1); add_px(12, 4, 1, 1); add_px(13, 4, 1, 1);
    run_frame("merge", 1'b0, -1);
  endtask

  task automatic test_sof_pixel();
    clear_px();
    add_px(0, 0, 1, 1); add_px(1, 0, 1, 0); add_px(2, 0, 1, 0);
    run_frame("sof_pixel", 1'b1, -1);
  endtask

  task automatic test_out_of_range();
    clear_px();
    add_px(0, 0, 1, 0);    add_px(640, 10, 1, 1); add_px(3, 512, 1, 1);
    add_px(639, 511, 1, 1); add_px(20, 20, 1, 0);
    run_frame("range_busy_cap", 1'b0, 2);
  endtask

  task automatic test_overflow();
    clear_px();
    for (int i = 0; i < 130; i++) add_px(i * 4, 1, 1, 1);
    run_frame("overflow", 1'b0, -1);
  endtask

  task automatic test_random();
    for (int f = 0; f < 4; f++) begin
      clear_px();
      for (int i = 0; i < 60; i++) begin
        if (i > 0 && $urandom_range(0, 3) == 0)
          add_px(px_x[i-1] + int'($urandom_range(0, 3)), px_y[i-1], 1, 1);
        else
          add_px(int'($urandom_range(0, 660)), int'($urandom_range(0, 530)),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
      end
      run_frame($sformatf("random%0d", f), 1'($urandom_range(0, 1)), -1);
    end
  endtask

  task automatic test_reset_mid();
    obs_w.delete();
    done_cnt = 0;
    capture_start = 1'b1;
    tick();
    capture_start = 1'b0;
    tick();
    frame_start = 1'b1; drive(1, 1, 1'b1, 1'b1); tick();
    frame_start = 1'b0; drive(9, 1, 1'b1, 1'b1); tick();
    drive(0, 0, 1'b0, 1'b0);
    tick();
    tick();
    tests++;
    if (obs_w.size() !== 2) begin
      fails++;
      $display("FAIL rstmid_writes: got %0d, want 2", obs_w.size());
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tests++;
    if (busy !== 1'b0 || bad_point_num !== 7'd0 || wen_lut !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_state: busy=%b bpn=%0d wen=%b, want 0 0 0", busy, bad_point_num, wen_lut);
    end
    frame_start = 1'b1; tick();
    frame_start = 1'b0;
    repeat (10) tick();
    tests++;
    if (done_cnt !== 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_nodone: done cycles=%0d busy=%b, want 0 0", done_cnt, busy);
    end
    prev_bpn = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_merge();
    test_sof_pixel();
    test_out_of_range();
    test_overflow();
    test_random();
    test_reset_mid();
    test_basic();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
